// File: rtl/sprite_pkg.sv
// Sprite overlay constants: transparent key colour, position record, player sprite size.
package sprite_pkg;
  localparam logic [11:0] KEY_DEFAULT = 12'hF0F;
  localparam int PLAYER_W = 48;
  localparam int PLAYER_H = 64;

  typedef struct packed {
    logic [11:0] x;
    logic [11:0] y;
  } sprite_pos_t;
endpackage

// File: rtl/vga_pkg.sv
// VGA pipeline shared widths, screen geometry and the bundled timing/colour word.
package vga_pkg;
  localparam int HCNT_W     = 11;
  localparam int VCNT_W     = 11;
  localparam int RGB_W      = 12;
  localparam int HOR_PIXELS = 1024;
  localparam int VER_PIXELS = 768;

  typedef struct packed {
    logic [HCNT_W-1:0] hcount;
    logic [VCNT_W-1:0] vcount;
    logic              hsync;
    logic              vsync;
    logic              hblnk;
    logic              vblnk;
    logic [RGB_W-1:0]  rgb;
  } vga_t;

  localparam int VGA_T_W = $bits(vga_t);
endpackage

// File: rtl/vga_if.sv
// VGA timing and colour bundle passed between pixel pipeline stages.
interface vga_if;
  import vga_pkg::*;
  logic [HCNT_W-1:0] hcount;
  logic [VCNT_W-1:0] vcount;
  logic              hsync;
  logic              vsync;
  logic              hblnk;
  logic              vblnk;
  logic [RGB_W-1:0]  rgb;

  modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/vga_delay.sv
// vga_delay: reset-to-zero shift register, DEPTH cycles of latency.
// No backpressure: accepts and emits one word every clock.
module vga_delay #(
  parameter int DEPTH = 1,
  parameter int W     = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);
  logic [W-1:0] stage [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[DEPTH-1];
endmodule

// File: rtl/draw_sprite.sv
// draw_sprite: frame-latched sprite overlay, ROM_LAT+2 cycles vga_in->vga_out, no stalls or backpressure.
// Horizontal mirroring is built only when DRAW_SPRITE_MIRROR_EN is defined.
module draw_sprite
  import vga_pkg::*;
  import sprite_pkg::*;
#(
  parameter int          SPR_W     = PLAYER_W,
  parameter int          SPR_H     = PLAYER_H,
  parameter int          ROM_LAT   = 1,
  parameter logic [11:0] KEY_COLOR = KEY_DEFAULT,
  parameter int          ADDR_W    = $clog2(SPR_W*SPR_H)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [11:0]       x_pos,
  input  logic [11:0]       y_pos,
  input  logic              enable,
  input  logic              mirror,
  input  logic [11:0]       rgb_pixel,
  output logic [ADDR_W-1:0] pixel_addr,
  vga_if.in                 vga_in,
  vga_if.out                vga_out
);
  sprite_pos_t pos_act;
  logic        en_act;
  logic        vblnk_q;
  logic        armed;
  logic        vblnk_rise;

  // armed blocks a false edge when vblnk is already high as reset releases.
  assign vblnk_rise = vga_in.vblnk & ~vblnk_q & armed;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vblnk_q <= 1'b0;
      armed   <= 1'b0;
      en_act  <= 1'b0;
      pos_act <= '0;
    end else begin
      vblnk_q <= vga_in.vblnk;
      armed   <= 1'b1;
      if (vblnk_rise) begin
        pos_act.x <= x_pos;
        pos_act.y <= y_pos;
        en_act    <= enable;
      end
    end
  end

  logic [11:0] h12, v12, dx, dy, col;
  logic [12:0] x_end, y_end;
  logic        h_in, v_in, hit;
  logic [ADDR_W-1:0] addr_next;

  assign h12   = {1'b0, vga_in.hcount};
  assign v12   = {1'b0, vga_in.vcount};
  assign x_end = {1'b0, pos_act.x} + 13'(SPR_W);
  assign y_end = {1'b0, pos_act.y} + 13'(SPR_H);
  assign h_in  = (h12 >= pos_act.x) && ({1'b0, h12} < x_end);
  assign v_in  = (v12 >= pos_act.y) && ({1'b0, v12} < y_end);
  assign hit   = en_act & h_in & v_in;
  assign dx    = h12 - pos_act.x;
  assign dy    = v12 - pos_act.y;

`ifdef DRAW_SPRITE_MIRROR_EN
  logic mir_act;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)             mir_act <= 1'b0;
    else if (vblnk_rise) mir_act <= mirror;
  end

  assign col = mir_act ? (12'(SPR_W - 1) - dx) : dx;
`else
  logic mirror_unused;
  assign mirror_unused = mirror;
  assign col = dx;
`endif

  assign addr_next = hit ? ADDR_W'(32'(dy) * SPR_W + 32'(col)) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pixel_addr <= '0;
    else     pixel_addr <= addr_next;
  end

  vga_t             vga_a, vga_d, vga_o;
  logic             hit_d;
  logic [VGA_T_W:0] dly_in, dly_out;

  always_comb begin
    vga_a        = '0;
    vga_a.hcount = vga_in.hcount;
    vga_a.vcount = vga_in.vcount;
    vga_a.hsync  = vga_in.hsync;
    vga_a.vsync  = vga_in.vsync;
    vga_a.hblnk  = vga_in.hblnk;
    vga_a.vblnk  = vga_in.vblnk;
    vga_a.rgb    = vga_in.rgb;
  end

  // First delay stage doubles as the stage-A register for hit and timing.
  assign dly_in         = {vga_a, hit};
  assign {vga_d, hit_d} = dly_out;

  vga_delay #(.DEPTH(ROM_LAT + 1), .W(VGA_T_W + 1)) u_delay (
    .clk  (clk),
    .rst  (rst),
    .din  (dly_in),
    .dout (dly_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vga_o <= '0;
    end else begin
      vga_o <= vga_d;
      if (hit_d && (rgb_pixel != KEY_COLOR)) vga_o.rgb <= rgb_pixel;
    end
  end

  assign vga_out.hcount = vga_o.hcount;
  assign vga_out.vcount = vga_o.vcount;
  assign vga_out.hsync  = vga_o.hsync;
  assign vga_out.vsync  = vga_o.vsync;
  assign vga_out.hblnk  = vga_o.hblnk;
  assign vga_out.vblnk  = vga_o.vblnk;
  assign vga_out.rgb    = vga_o.rgb;
endmodule
